// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a valid/ready input handshake, iterative
// shift-add multiply, optional iterative restoring divide, an internal
// accumulator and zero/carry/err status flags. One operation in flight.
// Optional feature macro: ALU_DIV_EN (DIV/MOD divider present when defined;
// when undefined, DIV/MOD return d=0 with err=1 in a single cycle).
module alu_seq #(
    parameter int WIDTH = 12,
    parameter int DW    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [DW-1:0]    d,
    output logic             zero,
    output logic             carry,
    output logic             err,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  opa_q, opa_d, opb_q, opb_d;
    logic [PW-1:0]     prod_q, prod_d;    // MUL product, or DIV quotient in the low bits
    logic [DW-1:0]     acc_q, acc_d;
    logic [DW-1:0]     d_q, d_d;
    logic              out_valid_q, out_valid_d;
    logic              zero_q, zero_d, carry_q, carry_d, err_q, err_d;

    logic              accept;
    logic              is_iter;
    logic [DW-1:0]     sc_res;
    logic              sc_carry, sc_err;
    logic [WIDTH:0]    add_w;
    logic [WIDTH-1:0]  sub_w, not_w, ones_w;
    logic [DW-1:0]     a_ext, acc_sum;
    logic [PW-1:0]     mul_step;
`ifdef ALU_DIV_EN
    logic [3:0]        op_q, op_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [WIDTH:0]    trial;
    logic              ge;
    logic [WIDTH-1:0]  rem_next;
    logic [PW-1:0]     quo_step;
`endif

    assign in_ready  = (state_q != S_ITER);
    assign busy      = ~in_ready;
    assign accept    = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign d         = d_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign err       = err_q;

    assign add_w   = {1'b0, a} + {1'b0, b};
    assign sub_w   = a - b;
    assign not_w   = ~a;
    assign ones_w  = '1;
    assign a_ext   = DW'(a);
    assign acc_sum = acc_q + a_ext;

    // One multiply step, MSB of the multiplier first.
    assign mul_step = (prod_q << 1) + (opb_q[cnt_q] ? {{WIDTH{1'b0}}, opa_q} : '0);

`ifdef ALU_DIV_EN
    // One restoring-divide step: bring in the next dividend bit, subtract if it fits.
    assign trial    = {rem_q, opa_q[cnt_q]};
    assign ge       = (trial >= {1'b0, opb_q});
    assign rem_next = ge ? (trial[WIDTH-1:0] - opb_q) : trial[WIDTH-1:0];
    assign quo_step = (prod_q << 1) | {{(PW-1){1'b0}}, ge};
`endif

    // Single-cycle result and flags; also flags which opcodes must iterate.
    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_err   = 1'b0;
        is_iter  = 1'b0;
        case (op)
            4'd0:  begin sc_res = DW'(add_w); sc_carry = add_w[WIDTH]; end
            4'd1:  begin sc_res = DW'(sub_w); sc_carry = (a < b); end
            4'd2:  sc_res = DW'(a & b);
            4'd3:  sc_res = DW'(a | b);
            4'd4:  sc_res = DW'(a ^ b);
            4'd5:  sc_res = DW'(not_w);
            4'd6:  sc_res = (32'(b) >= DW) ? '0 : (a_ext << b);
            4'd7:  sc_res = (32'(b) >= DW) ? '0 : (a_ext >> b);
            4'd8:  is_iter = 1'b1;
`ifdef ALU_DIV_EN
            4'd9:  begin
                if (b == '0) begin sc_res = DW'(ones_w); sc_err = 1'b1; end
                else is_iter = 1'b1;
            end
            4'd10: begin
                if (b == '0) begin sc_res = a_ext; sc_err = 1'b1; end
                else is_iter = 1'b1;
            end
`else
            4'd9:  sc_err = (ones_w != '0);
            4'd10: sc_err = 1'b1;
`endif
            4'd11: sc_res = {{(DW-1){1'b0}}, (a < b)};
            4'd12: sc_res = acc_sum;
            4'd13: sc_res = '0;
            4'd14: sc_res = a_ext;
            default: sc_res = '0;
        endcase
    end

    // FSM next-state, datapath updates and output register next values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        prod_d      = prod_q;
        acc_d       = acc_q;
        d_d         = d_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        err_d       = err_q;
        out_valid_d = 1'b0;
`ifdef ALU_DIV_EN
        op_d        = op_q;
        rem_d       = rem_q;
`endif
        case (state_q)
            S_ITER: begin
                cnt_d = cnt_q - CW'(1);
`ifdef ALU_DIV_EN
                if (op_q == 4'd8) prod_d = mul_step;
                else begin
                    prod_d = quo_step;
                    rem_d  = rem_next;
                end
`else
                prod_d = mul_step;
`endif
                if (cnt_q == '0) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
`ifdef ALU_DIV_EN
                    case (op_q)
                        4'd8:    d_d = DW'(mul_step);
                        4'd9:    d_d = DW'(quo_step);
                        default: d_d = DW'(rem_next);
                    endcase
`else
                    d_d = DW'(mul_step);
`endif
                    zero_d  = (d_d == '0);
                    carry_d = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (accept) begin
                    if (is_iter) begin
                        state_d = S_ITER;
                        cnt_d   = CW'(WIDTH - 1);
                        opa_d   = a;
                        opb_d   = b;
                        prod_d  = '0;
`ifdef ALU_DIV_EN
                        op_d    = op;
                        rem_d   = '0;
`endif
                    end else begin
                        out_valid_d = 1'b1;
                        d_d         = sc_res;
                        zero_d      = (sc_res == '0);
                        carry_d     = sc_carry;
                        err_d       = sc_err;
                        if (op == 4'd12) acc_d = acc_sum;
                        if (op == 4'd13) acc_d = '0;
                    end
                end
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            prod_q      <= '0;
            acc_q       <= '0;
            d_q         <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef ALU_DIV_EN
            op_q        <= '0;
            rem_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            d_q         <= d_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
`ifdef ALU_DIV_EN
            op_q        <= op_d;
            rem_q       <= rem_d;
`endif
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes expected results with their
// expected arrival cycle; an independent monitor pops and compares on out_valid.
module tb_alu_seq;
    localparam int W  = 12;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    op = 4'd0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          out_valid;
    logic [DW-1:0] d;
    logic          zero, carry, err, busy;

    alu_seq #(.WIDTH(W), .DW(DW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .d(d),
        .zero(zero), .carry(carry), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          z;
        logic          c;
        logic          e;
        int            cyc;
        string         name;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: compares every presented result against the scoreboard head.
    always @(posedge clk) begin
        #1;
        chk("busy_is_not_ready", DW'(busy), DW'(!in_ready));
        if (out_valid) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_out: got out_valid with d=%0d at cycle %0d, required none", d, cyc);
            end else begin
                cur = sb.pop_front();
                chk({cur.name, "_d"},     d,          cur.d);
                chk({cur.name, "_zero"},  DW'(zero),  DW'(cur.z));
                chk({cur.name, "_carry"}, DW'(carry), DW'(cur.c));
                chk({cur.name, "_err"},   DW'(err),   DW'(cur.e));
                chk({cur.name, "_cycle"}, DW'(cyc),   DW'(cur.cyc));
                $display("result %s: d=%0d z=%0b c=%0b e=%0b cycle=%0d", cur.name, d, zero, carry, err, cyc);
            end
        end
    end

    // Present one op, wait for acceptance, record the expected response.
    task automatic issue(input string nm, input logic [3:0] o, input int va, input int vb,
                         input logic [DW-1:0] ed, input logic ec, input logic ee, input int lat);
        exp_t e;
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        op = o;
        a = W'(va);
        b = W'(vb);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_accept: got in_ready=0 after %0d cycles, required 1", nm, guard);
            in_valid = 1'b0;
            return;
        end
        e.d = ed; e.z = (ed == '0); e.c = ec; e.e = ee;
        e.cyc = cyc + 1 + lat; e.name = nm;
        sb.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        int guard;
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_d", d, 0);
        chk("rst_out_valid", DW'(out_valid), 0);
        chk("rst_in_ready", DW'(in_ready), 1);
        chk("rst_flags", DW'({zero, carry, err, busy}), 0);
        rst = 1'b0;

        // Back-to-back single-cycle ops
        issue("add_65_8", 4'd0, 65, 8, 73, 0, 0, 0);
        issue("sub_65_8", 4'd1, 65, 8, 57, 0, 0, 0);
        issue("shl_65_8", 4'd6, 65, 8, 16640, 0, 0, 0);
        issue("cmp_65_8", 4'd11, 65, 8, 0, 0, 0, 0);
        issue("sub_8_65", 4'd1, 8, 65, 4039, 1, 0, 0);
        issue("add_4095_1", 4'd0, 4095, 1, 4096, 1, 0, 0);
        idle();
        repeat (2) @(negedge clk);
        chk("hold_d", d, 4096);
        chk("hold_carry", DW'(carry), 1);
        chk("hold_out_valid", DW'(out_valid), 0);

        issue("and_65_8", 4'd2, 65, 8, 0, 0, 0, 0);
        issue("or_65_8", 4'd3, 65, 8, 73, 0, 0, 0);
        issue("xor_65_8", 4'd4, 65, 8, 73, 0, 0, 0);
        issue("not_65", 4'd5, 65, 0, 4030, 0, 0, 0);
        issue("shr_65_2", 4'd7, 65, 2, 16, 0, 0, 0);
        issue("shl_b32", 4'd6, 65, 32, 0, 0, 0, 0);
        issue("shl_4095_20", 4'd6, 4095, 20, 32'hFFF0_0000, 0, 0, 0);
        issue("shr_b40", 4'd7, 4095, 40, 0, 0, 0, 0);
        issue("cmp_8_65", 4'd11, 8, 65, 1, 0, 0, 0);
        issue("pass_65", 4'd14, 65, 8, 65, 0, 0, 0);
        issue("nop", 4'd15, 65, 8, 0, 0, 0, 0);

        // MUL with ignored ADD requests while busy
        issue("mul_65_8", 4'd8, 65, 8, 520, 0, 0, W);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            op = 4'd0;
            chk("mul_busy_in_ready", DW'(in_ready), 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("mul_done_in_ready", DW'(in_ready), 1);

        // Iterative ops back-to-back (second accepted in the DONE cycle)
        issue("mul_4095_4095", 4'd8, 4095, 4095, 16769025, 0, 0, W);
`ifdef ALU_DIV_EN
        issue("div_65_8", 4'd9, 65, 8, 8, 0, 0, W);
        issue("mod_65_8", 4'd10, 65, 8, 1, 0, 0, W);
        issue("div_by_0", 4'd9, 65, 0, 4095, 0, 1, 0);
        issue("mod_by_0", 4'd10, 65, 0, 65, 0, 1, 0);
        issue("div_4000_7", 4'd9, 4000, 7, 571, 0, 0, W);
`else
        issue("div_off", 4'd9, 65, 8, 0, 0, 1, 0);
        issue("mod_off", 4'd10, 65, 8, 0, 0, 1, 0);
        issue("div_off_b0", 4'd9, 65, 0, 0, 0, 1, 0);
`endif

        // Accumulator
        issue("acc_1", 4'd12, 65, 0, 65, 0, 0, 0);
        issue("acc_2", 4'd12, 65, 0, 130, 0, 0, 0);
        issue("acc_3", 4'd12, 65, 0, 195, 0, 0, 0);
        issue("clr", 4'd13, 65, 0, 0, 0, 0, 0);
        issue("acc_8", 4'd12, 8, 0, 8, 0, 0, 0);
        issue("acc_100", 4'd12, 100, 0, 108, 0, 0, 0);

        // Reset in the middle of a MUL
        issue("mul_aborted", 4'd8, 65, 8, 520, 0, 0, W);
        idle();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("midrst_d", d, 0);
        chk("midrst_out_valid", DW'(out_valid), 0);
        chk("midrst_in_ready", DW'(in_ready), 1);
        repeat (W + 4) @(negedge clk);
        issue("acc_after_rst", 4'd12, 5, 0, 5, 0, 0, 0);
        idle();

        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d results outstanding, required 0", sb.size());
        end
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered ALU: next generation of the 4-bit-opcode ALU, with generic operand/result widths, a valid/ready input handshake, iterative multiply/divide, an internal accumulator and status flags. Sits between the instruction sequencer and the result register file; one operation in flight at a time. Single-cycle ops have 1-cycle latency; iterative ops hold off new input until done.

## Interface
- WIDTH, 12, operand width (≥ 4)
- DW, 32, result width (≥ 2*WIDTH)
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  operation request
- in_ready  output  1  block can accept; transfer when in_valid & in_ready at a rising edge
- op  input  4  opcode
- a  input  WIDTH  operand A (unsigned)
- b  input  WIDTH  operand B (unsigned)
- out_valid  output  1  one-cycle pulse, d/flags valid
- d  output  DW  result, held until next result
- zero  output  1  d == 0
- carry  output  1  ADD carry-out / SUB borrow, else 0
- err  output  1  divide by zero or compiled-out op
- busy  output  1  iterative op in progress (== ~in_ready)

## Operation
- Opcodes (results zero-extended to DW):
  - 0 ADD: a+b (WIDTH+1 bits); carry = bit WIDTH
  - 1 SUB: (a−b) mod 2^WIDTH; carry = (a < b)
  - 2 AND, 3 OR, 4 XOR: bitwise; 5 NOT: ~a (WIDTH bits)
  - 6 SHL: a << b within DW; 7 SHR: a >> b; b ≥ DW → 0
  - 8 MUL: a*b, 2*WIDTH bits, iterative shift-add
  - 9 DIV: a/b; 10 MOD: a%b; iterative restoring divide
  - 11 CMP: 1 if a < b else 0
  - 12 ACC: acc ← (acc + a) mod 2^DW; d = new acc
  - 13 CLR: acc ← 0; d = 0
  - 14 PASS: a; 15 NOP: d = 0
- b = 0 on DIV/MOD: no iteration, 1-cycle result; DIV d = 2^WIDTH−1, MOD d = a, err = 1.
- FSM: IDLE (in_ready=1) → accept single-cycle op → stays IDLE; accept MUL or DIV/MOD with b≠0 → ITER (counter = WIDTH−1 down to 0, one bit per cycle) → DONE (out_valid pulse, in_ready=1) → IDLE, or straight back to ITER on a new iterative accept in DONE.
- in_valid while in_ready = 0: ignored, not queued; requester must hold it.
- zero computed on the final d; carry/err are 0 except where stated.
- acc is modified only by ops 12/13 and reset.

## Timing
- Reset: d=0, out_valid=0, zero=0, carry=0, err=0, in_ready=1, busy=0, acc=0, FSM=IDLE, counter=0.
- Reset during ITER: operation aborted, no out_valid, outputs at reset values next cycle.
- Single-cycle op accepted at edge k: out_valid=1 and d valid after edge k; back-to-back accepts give out_valid every cycle.
- Iterative op accepted at edge k: in_ready=0 after edges k..k+WIDTH−1; out_valid=1 and in_ready=1 after edge k+WIDTH (latency WIDTH+1 edges counting the accept edge as 1... i.e. result in cycle k+WIDTH+1). New op accepted in DONE cycle.
- Between results d/flags hold their last value; out_valid is 0.

## Configuration
- ALU_DIV_EN defined: DIV/MOD implemented as above.
- ALU_DIV_EN undefined: no divider logic; ops 9/10 complete in 1 cycle with d=0, err=1; FSM enters ITER for MUL only.

## Test plan
- Reset: assert rst 2 cycles mid-MUL → no out_valid, d=0, in_ready=1, acc=0.
- WIDTH=12, a=65, b=8: ADD → d=73 carry=0; SUB → 57; SHL → 16640; CMP → 0; each out_valid 1 cycle after accept, back-to-back.
- SUB a=8, b=65 → d=4039, carry=1; ADD a=4095, b=1 → d=4096, carry=1, zero=0.
- MUL a=65, b=8 → d=520 in cycle k+13; in_ready low 12 cycles; in_valid with ADD during busy ignored.
- DIV/MOD a=65, b=8 → 8 then 1; b=0 → DIV d=4095, err=1 in 1 cycle; with ALU_DIV_EN undefined → d=0, err=1.
- ACC a=65 three times → 65, 130, 195; CLR → d=0, zero=1; next ACC a=8 → 8.
